line_responder: RTL and testbench

LINE_RESPONDER -- requirements
Module: line_responder

---
 rtl/line_responder.sv | 147 ++++++++++++++
 tb/tb_line_responder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/line_responder.sv
// line_responder: breaks a 128-bit line fill or write-back into eight
// 16-bit word-bus beats, then reports completion with a one-cycle pulse.
//
// Ports:
//   clk, rst          sole clock; asynchronous active-high reset
//   line_strobe       line request valid (sampled only in IDLE)
//   line_write        1 = write-back, 0 = fill
//   line_addr[15:0]   line byte address, low nibble ignored
//   line_wdata[127:0] write-back data, word 0 in bits [15:0]
//   line_rdata[127:0] fill data, held until the next fill's first beat
//   line_resp         one-cycle completion pulse
//   busy              high whenever a transaction is in flight
//   mem_strobe        word-bus request, held through a stall
//   mem_write         word-bus write enable
//   mem_addr[15:0]    word-bus byte address
//   mem_wdata[15:0]   word-bus write data
//   mem_rdata[15:0]   word-bus read data, valid with mem_resp
//   mem_resp          word-bus beat completion (used only in BEAT)
module line_responder (
    input  logic         clk,
    input  logic         rst,
    input  logic         line_strobe,
    input  logic         line_write,
    input  logic [15:0]  line_addr,
    input  logic [127:0] line_wdata,
    output logic [127:0] line_rdata,
    output logic         line_resp,
    output logic         busy,
    output logic         mem_strobe,
    output logic         mem_write,
    output logic [15:0]  mem_addr,
    output logic [15:0]  mem_wdata,
    input  logic [15:0]  mem_rdata,
    input  logic         mem_resp
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BEAT   = 3'd1,
        GAP    = 3'd2,
        ACK    = 3'd3,
        TOGGLE = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    logic [11:0]  base;
    logic         wr;
    logic [127:0] wdata;
    logic [2:0]   cnt;

    logic accept;
    logic beat_done;
    logic last_beat;

    // Byte offset within the line is meaningless for whole-line transfers.
    logic unused_offset;
    assign unused_offset = ^line_addr[3:0];

    assign accept    = (state == IDLE) && line_strobe;
    assign beat_done = (state == BEAT) && mem_resp;
    assign last_beat = (cnt == 3'd7);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mem_strobe = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = 16'h0000;
        mem_wdata  = 16'h0000;
        line_resp  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (line_strobe) begin
                    state_next = BEAT;
                end
            end
            BEAT: begin
                mem_strobe = 1'b1;
                mem_write  = wr;
                // Concatenation keeps the line base fixed: no carry
                // out of the word index can reach the upper bits.
                mem_addr   = {base, cnt, 1'b0};
                mem_wdata  = wdata[{cnt, 4'h0} +: 16];
                if (mem_resp) begin
                    state_next = last_beat ? ACK : GAP;
                end
            end
            GAP: begin
                state_next = BEAT;
            end
            ACK: begin
                line_resp  = 1'b1;
                state_next = TOGGLE;
            end
            TOGGLE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request fields are captured once at acceptance so later changes
    // on the line-side inputs cannot disturb the transfer in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base  <= 12'h000;
            wr    <= 1'b0;
            wdata <= 128'h0;
        end else if (accept) begin
            base  <= line_addr[15:4];
            wr    <= line_write;
            wdata <= line_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 3'd0;
        end else if (accept) begin
            cnt <= 3'd0;
        end else if (beat_done && !last_beat) begin
            cnt <= cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_rdata <= 128'h0;
        end else if (beat_done && !wr) begin
            line_rdata[{cnt, 4'h0} +: 16] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_line_responder.sv
// Directed bench for line_responder: fills, write-back, stalled beats,
// reset mid-line and a continuously held request.
module tb_line_responder;

    logic         clk;
    logic         rst;
    logic         line_strobe;
    logic         line_write;
    logic [15:0]  line_addr;
    logic [127:0] line_wdata;
    logic [127:0] line_rdata;
    logic         line_resp;
    logic         busy;
    logic         mem_strobe;
    logic         mem_write;
    logic [15:0]  mem_addr;
    logic [15:0]  mem_wdata;
    logic [15:0]  mem_rdata;
    logic         mem_resp;

    int total;
    int passed;

    line_responder dut (
        .clk        (clk),
        .rst        (rst),
        .line_strobe(line_strobe),
        .line_write (line_write),
        .line_addr  (line_addr),
        .line_wdata (line_wdata),
        .line_rdata (line_rdata),
        .line_resp  (line_resp),
        .busy       (busy),
        .mem_strobe (mem_strobe),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_resp   (mem_resp)
    );

    // Word memory model: each word reads back as A000 + its address.
    assign mem_rdata = 16'hA000 + mem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One full line transaction with d wait cycles before each mem_resp.
    // mem_resp is also pulsed through GAP, ACK, TOGGLE and IDLE.
    task automatic do_line(input logic wr, input logic [15:0] addr,
                           input logic [127:0] wd, input int d,
                           input logic [127:0] exp_rd);
        logic [15:0] base;
        int cyc;
        base        = {addr[15:4], 4'h0};
        line_strobe = 1'b1;
        line_write  = wr;
        line_addr   = addr;
        line_wdata  = wd;
        mem_resp    = 1'b0;
        chk("idle_busy", 128'(busy), 128'(1'b0));
        tick();
        cyc         = 1;
        line_strobe = 1'b0;
        line_write  = ~wr;
        line_addr   = 16'hFFFF;
        line_wdata  = '1;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k <= d; k++) begin
                chk("beat_strobe", 128'(mem_strobe), 128'(1'b1));
                chk("beat_write", 128'(mem_write), 128'(wr));
                chk("beat_addr", 128'(mem_addr),
                    128'(base + 16'(2 * i)));
                if (wr) begin
                    chk("beat_wdata", 128'(mem_wdata),
                        128'(wd[16*i +: 16]));
                end
                chk("beat_noresp", 128'(line_resp), 128'(1'b0));
                mem_resp = (k == d);
                tick();
                cyc++;
            end
            mem_resp = 1'b1;
            if (i < 7) begin
                chk("gap_strobe", 128'(mem_strobe), 128'(1'b0));
                chk("gap_write", 128'(mem_write), 128'(1'b0));
                tick();
                cyc++;
            end
        end
        chk("ack_resp", 128'(line_resp), 128'(1'b1));
        chk("ack_cycle", 128'(cyc), 128'(8 * d + 16));
        chk("ack_strobe", 128'(mem_strobe), 128'(1'b0));
        tick();
        chk("toggle_resp", 128'(line_resp), 128'(1'b0));
        chk("toggle_busy", 128'(busy), 128'(1'b1));
        tick();
        chk("done_busy", 128'(busy), 128'(1'b0));
        tick();
        mem_resp = 1'b0;
        chk("idle_pulse_busy", 128'(busy), 128'(1'b0));
        chk("idle_strobe", 128'(mem_strobe), 128'(1'b0));
        chk("line_rdata", line_rdata, exp_rd);
    endtask

    initial begin
        int resps;
        int resp16;
        int resp34;
        logic busy17;
        logic busy18;
        logic strobe19;
        logic busy36;

        total       = 0;
        passed      = 0;
        rst         = 1'b1;
        line_strobe = 1'b0;
        line_write  = 1'b0;
        line_addr   = 16'h0000;
        line_wdata  = 128'h0;
        mem_resp    = 1'b0;
        #1;
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_rdata", line_rdata, 128'h0);
        chk("rst_resp", 128'(line_resp), 128'(1'b0));
        chk("rst_mstrobe", 128'(mem_strobe), 128'(1'b0));
        chk("rst_mwrite", 128'(mem_write), 128'(1'b0));
        chk("rst_maddr", 128'(mem_addr), 128'(16'h0));
        chk("rst_mwdata", 128'(mem_wdata), 128'(16'h0));
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Fill at 3018 -> words D010..D01E, mem_resp always ready.
        do_line(1'b0, 16'h3018, 128'h0, 0,
                128'hD01E_D01C_D01A_D018_D016_D014_D012_D010);

        // Write-back at 0040; fill data must be left alone.
        do_line(1'b1, 16'h0040,
                128'h7777_6666_5555_4444_3333_2222_1111_0000, 0,
                128'hD01E_D01C_D01A_D018_D016_D014_D012_D010);

        // Fill at 1234 with three wait cycles per beat.
        do_line(1'b0, 16'h1234, 128'h0, 3,
                128'hB23E_B23C_B23A_B238_B236_B234_B232_B230);

        // Reset during beat 4 of a fill at 5000.
        line_strobe = 1'b1;
        line_write  = 1'b0;
        line_addr   = 16'h5000;
        mem_resp    = 1'b1;
        tick();
        line_strobe = 1'b0;
        repeat (8) tick();
        chk("b4_strobe", 128'(mem_strobe), 128'(1'b1));
        chk("b4_addr", 128'(mem_addr), 128'(16'h5008));
        rst = 1'b1;
        #1;
        chk("arst_strobe", 128'(mem_strobe), 128'(1'b0));
        chk("arst_busy", 128'(busy), 128'(1'b0));
        chk("arst_addr", 128'(mem_addr), 128'(16'h0));
        chk("arst_rdata", line_rdata, 128'h0);
        resps = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (line_resp) resps++;
        end
        rst      = 1'b0;
        mem_resp = 1'b0;
        tick();
        if (line_resp) resps++;
        chk("arst_noresp", 128'(resps), 128'(0));

        do_line(1'b0, 16'h7FF6, 128'h0, 0,
                128'h1FFE_1FFC_1FFA_1FF8_1FF6_1FF4_1FF2_1FF0);

        // Held request: next accept only once back in IDLE at cycle 18.
        line_strobe = 1'b1;
        line_write  = 1'b0;
        line_addr   = 16'h0100;
        mem_resp    = 1'b1;
        resps       = 0;
        resp16      = 0;
        resp34      = 0;
        busy17      = 1'b0;
        busy18      = 1'b1;
        strobe19    = 1'b0;
        busy36      = 1'b1;
        for (int c = 0; c <= 36; c++) begin
            if (line_resp) resps++;
            if (c == 16) resp16 = int'(line_resp);
            if (c == 34) resp34 = int'(line_resp);
            if (c == 17) busy17 = busy;
            if (c == 18) busy18 = busy;
            if (c == 19) strobe19 = mem_strobe;
            if (c == 36) busy36 = busy;
            if (c == 35) line_strobe = 1'b0;
            if (c < 36) tick();
        end
        mem_resp = 1'b0;
        chk("hold_resps", 128'(resps), 128'(2));
        chk("hold_resp16", 128'(resp16), 128'(1));
        chk("hold_resp34", 128'(resp34), 128'(1));
        chk("hold_toggle", 128'(busy17), 128'(1'b1));
        chk("hold_idle18", 128'(busy18), 128'(1'b0));
        chk("hold_beat19", 128'(strobe19), 128'(1'b1));
        chk("hold_idle36", 128'(busy36), 128'(1'b0));
        chk("hold_rdata", line_rdata,
            128'hA10E_A10C_A10A_A108_A106_A104_A102_A100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
